// File: rtl/raster_walker.sv
// raster_walker: triangle traversal engine. Latches three vertices, sets up
// the doubled area and three edge functions in one cycle, then walks pixels in
// raster order emitting barycentric weights over a valid/ready stream.
// Optional feature: define RASTER_BBOX_EN to restrict the walk to the clamped
// vertex bounding box instead of the full H_RES x V_RES frame.
module raster_walker #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  x0,
   input  logic [9:0]  y0,
   input  logic [9:0]  x1,
   input  logic [9:0]  y1,
   input  logic [9:0]  x2,
   input  logic [9:0]  y2,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [9:0]  out_x,
   output logic [9:0]  out_y,
   output logic        visible,
   output logic [19:0] ua,
   output logic [19:0] va,
   output logic [19:0] wa,
   output logic [19:0] a,
   output logic        out_last
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WALK} state_t;

   localparam logic [9:0] X_LAST = 10'(H_RES - 1);
   localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

   state_t state_q, state_d;

   logic [9:0] vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
   logic [9:0] cur_x_q, cur_y_q;
   logic [9:0] org_x, org_y, x_lo, x_hi, y_hi;
   logic signed [21:0] sx0, sy0, sx1, sy1, sx2, sy2, ox, oy;
   logic signed [21:0] st0_c, st1_c, st2_c, ln0_c, ln1_c, ln2_c;
   logic signed [21:0] e0_c, e1_c, e2_c, area_c;
   logic signed [21:0] e0_q, e1_q, e2_q, ls0_q, ls1_q, ls2_q;
   logic signed [21:0] st0_q, st1_q, st2_q, ln0_q, ln1_q, ln2_q;
   logic [19:0] a_q;
   logic        a_nz_q;
   logic        neg;
   logic        fire, at_x_end;

   function automatic logic signed [21:0] cond_neg(input logic signed [21:0] v,
                                                   input logic n);
      return n ? -v : v;
   endfunction

`ifdef RASTER_BBOX_EN
   logic [9:0] box_x_lo_c, box_x_hi_c, box_y_lo_c, box_y_hi_c;
   logic [9:0] x_lo_q, x_hi_q, y_hi_q;

   function automatic logic [9:0] min3(input logic [9:0] p, q, r);
      logic [9:0] m;
      m = (p < q) ? p : q;
      return (m < r) ? m : r;
   endfunction

   function automatic logic [9:0] max3(input logic [9:0] p, q, r);
      logic [9:0] m;
      m = (p > q) ? p : q;
      return (m > r) ? m : r;
   endfunction

   function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign box_x_lo_c = clamp(min3(vx0_q, vx1_q, vx2_q), X_LAST);
   assign box_x_hi_c = clamp(max3(vx0_q, vx1_q, vx2_q), X_LAST);
   assign box_y_lo_c = clamp(min3(vy0_q, vy1_q, vy2_q), Y_LAST);
   assign box_y_hi_c = clamp(max3(vy0_q, vy1_q, vy2_q), Y_LAST);
   assign org_x = box_x_lo_c;
   assign org_y = box_y_lo_c;
   assign x_lo  = x_lo_q;
   assign x_hi  = x_hi_q;
   assign y_hi  = y_hi_q;

   // capture the walk box during setup
   always_ff @(posedge clk) begin
      if (state_q == S_SETUP) begin
         x_lo_q <= box_x_lo_c;
         x_hi_q <= box_x_hi_c;
         y_hi_q <= box_y_hi_c;
      end
   end
`else
   assign org_x = '0;
   assign org_y = '0;
   assign x_lo  = '0;
   assign x_hi  = X_LAST;
   assign y_hi  = Y_LAST;
`endif

   assign sx0 = signed'({12'd0, vx0_q});
   assign sy0 = signed'({12'd0, vy0_q});
   assign sx1 = signed'({12'd0, vx1_q});
   assign sy1 = signed'({12'd0, vy1_q});
   assign sx2 = signed'({12'd0, vx2_q});
   assign sy2 = signed'({12'd0, vy2_q});
   assign ox  = signed'({12'd0, org_x});
   assign oy  = signed'({12'd0, org_y});

   // per-pixel x step (st*) and per-line step (ln*) of each edge function
   assign st0_c = sy1 - sy2;
   assign st1_c = sy2 - sy0;
   assign st2_c = sy0 - sy1;
   assign ln0_c = sx2 - sx1;
   assign ln1_c = sx0 - sx2;
   assign ln2_c = sx1 - sx0;

   assign e0_c   = ln0_c * (oy - sy1) + st0_c * (ox - sx1);
   assign e1_c   = ln1_c * (oy - sy2) + st1_c * (ox - sx2);
   assign e2_c   = ln2_c * (oy - sy0) + st2_c * (ox - sx0);
   assign area_c = ln0_c * (sy0 - sy1) + st0_c * (sx0 - sx1);
   assign neg    = area_c[21];

   assign fire     = (state_q == S_WALK) && out_ready;
   assign at_x_end = (cur_x_q == x_hi);

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: state_d = S_WALK;
         S_WALK:  if (fire && out_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state register and pixel position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cur_x_q <= '0;
         cur_y_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_SETUP) begin
            cur_x_q <= org_x;
            cur_y_q <= org_y;
         end else if (fire && !out_last) begin
            if (at_x_end) begin
               cur_x_q <= x_lo;
               cur_y_q <= cur_y_q + 10'd1;
            end else begin
               cur_x_q <= cur_x_q + 10'd1;
            end
         end
      end
   end

   // vertex latch, setup of edges/area, incremental edge walk
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && start) begin
         vx0_q <= x0; vy0_q <= y0;
         vx1_q <= x1; vy1_q <= y1;
         vx2_q <= x2; vy2_q <= y2;
      end
      if (state_q == S_SETUP) begin
         e0_q   <= cond_neg(e0_c, neg);
         e1_q   <= cond_neg(e1_c, neg);
         e2_q   <= cond_neg(e2_c, neg);
         ls0_q  <= cond_neg(e0_c, neg);
         ls1_q  <= cond_neg(e1_c, neg);
         ls2_q  <= cond_neg(e2_c, neg);
         st0_q  <= cond_neg(st0_c, neg);
         st1_q  <= cond_neg(st1_c, neg);
         st2_q  <= cond_neg(st2_c, neg);
         ln0_q  <= cond_neg(ln0_c, neg);
         ln1_q  <= cond_neg(ln1_c, neg);
         ln2_q  <= cond_neg(ln2_c, neg);
         a_q    <= 20'(cond_neg(area_c, neg));
         a_nz_q <= (area_c != '0);
      end else if (fire) begin
         if (at_x_end) begin
            e0_q  <= ls0_q + ln0_q;
            e1_q  <= ls1_q + ln1_q;
            e2_q  <= ls2_q + ln2_q;
            ls0_q <= ls0_q + ln0_q;
            ls1_q <= ls1_q + ln1_q;
            ls2_q <= ls2_q + ln2_q;
         end else begin
            e0_q <= e0_q + st0_q;
            e1_q <= e1_q + st1_q;
            e2_q <= e2_q + st2_q;
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_WALK);
   assign out_x     = cur_x_q;
   assign out_y     = cur_y_q;
   assign out_last  = out_valid && at_x_end && (cur_y_q == y_hi);
   assign visible   = out_valid && a_nz_q && !e0_q[21] && !e1_q[21] && !e2_q[21];
   assign ua        = visible ? 20'(e0_q) : '0;
   assign va        = visible ? 20'(e1_q) : '0;
   assign wa        = visible ? 20'(e2_q) : '0;
   assign a         = out_valid ? a_q : '0;

endmodule

// File: tb/tb_raster_walker.sv
// tb_raster_walker: directed bench for raster_walker on an 8x4 frame.
// Expected weights come from hand-derived linear edge formulas per triangle.
module tb_raster_walker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [9:0]  x0, y0, x1, y1, x2, y2;
   logic        busy, out_valid, out_ready, visible, out_last;
   logic [9:0]  out_x, out_y;
   logic [19:0] ua, va, wa, a;

   int n_cmp = 0;
   int n_bad = 0;

   raster_walker #(.H_RES(8), .V_RES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .visible(visible),
      .ua(ua), .va(va), .wa(wa), .a(a), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // kind 0: (0,0),(4,0),(0,4); 1: reversed winding; 2: collinear; 3: (1,1),(3,1),(1,3)
   task automatic model(input int kind, input int x, input int y,
                        output int vis, output int eu, output int ev,
                        output int ew, output int ea);
      int e0, e1, e2;
      case (kind)
         0: begin e0 = 16 - 4*x - 4*y; e1 = 4*x; e2 = 4*y; ea = 16; end
         1: begin e0 = 16 - 4*x - 4*y; e1 = 4*y; e2 = 4*x; ea = 16; end
         2: begin e0 = 0; e1 = 0; e2 = 0; ea = 0; end
         default: begin e0 = 8 - 2*x - 2*y; e1 = 2*x - 2; e2 = 2*y - 2; ea = 4; end
      endcase
      vis = (ea != 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ? 1 : 0;
      eu = vis ? e0 : 0;
      ev = vis ? e1 : 0;
      ew = vis ? e2 : 0;
   endtask

   task automatic begin_walk(input int v0x, v0y, v1x, v1y, v2x, v2y);
      x0 = 10'(v0x); y0 = 10'(v0y);
      x1 = 10'(v1x); y1 = 10'(v1y);
      x2 = 10'(v2x); y2 = 10'(v2y);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x0 = 10'd1023; y0 = 10'd517; x1 = 10'd3; y1 = 10'd999; x2 = 10'd77; y2 = 10'd0;
      chk("setup_busy", 32'(busy), 1);
      chk("setup_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("first_valid", 32'(out_valid), 1);
   endtask

   // called at a negedge; returns at the negedge after the last transfer
   task automatic run_walk(input string name, input int kind,
                           input int v0x, v0y, v1x, v1y, v2x, v2y,
                           input int xl, xh, yl, yh, input int vis_exp, input bit bp);
      int w, total, n, vis_cnt, cyc, vis, eu, ev, ew, ea, ex, ey;
      bit done, bp_done;
      logic [9:0] sx, sy;
      logic [19:0] su;
      w = xh - xl + 1;
      total = w * (yh - yl + 1);
      n = 0; vis_cnt = 0; cyc = 0; done = 0; bp_done = 0;
      begin_walk(v0x, v0y, v1x, v1y, v2x, v2y);
      while (!done && cyc < 500) begin
         if (out_valid) begin
            ex = xl + n % w;
            ey = yl + n / w;
            if (bp && !bp_done && ex == 3 && ey == yl) begin
               out_ready = 1'b0;
               sx = out_x; sy = out_y; su = ua;
               for (int k = 0; k < 5; k++) begin
                  @(negedge clk);
                  chk("bp_valid", 32'(out_valid), 1);
                  chk("bp_x", 32'(out_x), 32'(sx));
                  chk("bp_y", 32'(out_y), 32'(sy));
                  chk("bp_ua", 32'(ua), 32'(su));
               end
               out_ready = 1'b1;
               bp_done = 1;
            end
            model(kind, ex, ey, vis, eu, ev, ew, ea);
            chk({name, "_x"}, 32'(out_x), 32'(ex));
            chk({name, "_y"}, 32'(out_y), 32'(ey));
            chk({name, "_vis"}, 32'(visible), 32'(vis));
            chk({name, "_ua"}, 32'(ua), 32'(eu));
            chk({name, "_va"}, 32'(va), 32'(ev));
            chk({name, "_wa"}, 32'(wa), 32'(ew));
            chk({name, "_a"}, 32'(a), 32'(ea));
            chk({name, "_last"}, 32'(out_last), (n == total - 1) ? 32'd1 : 32'd0);
            vis_cnt += int'(visible);
            n++;
            if (out_last) done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      chk({name, "_records"}, 32'(n), 32'(total));
      chk({name, "_vis_count"}, 32'(vis_cnt), 32'(vis_exp));
      if (bp) chk({name, "_bp_seen"}, 32'(bp_done), 1);
      chk({name, "_end_valid"}, 32'(out_valid), 0);
      chk({name, "_end_busy"}, 32'(busy), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_vis"}, 32'(visible), 0);
      chk({tag, "_last"}, 32'(out_last), 0);
      chk({tag, "_ua"}, 32'(ua), 0);
      chk({tag, "_va"}, 32'(va), 0);
      chk({tag, "_wa"}, 32'(wa), 0);
      chk({tag, "_a"}, 32'(a), 0);
      chk({tag, "_x"}, 32'(out_x), 0);
      chk({tag, "_y"}, 32'(out_y), 0);
   endtask

   initial begin
      int fx_hi;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
`ifdef RASTER_BBOX_EN
      fx_hi = 4;
`else
      fx_hi = 7;
`endif
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // abort a walk part way through with reset
      begin_walk(0, 0, 4, 0, 0, 4);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_walk("ccw", 0, 0, 0, 4, 0, 0, 4, 0, fx_hi, 0, 3, 14, 1'b1);
      run_walk("rev", 1, 0, 0, 0, 4, 4, 0, 0, fx_hi, 0, 3, 14, 1'b0);
      run_walk("coll", 2, 0, 0, 2, 2, 4, 4, 0, fx_hi, 0, 3, 0, 1'b0);
`ifdef RASTER_BBOX_EN
      run_walk("bbox", 3, 1, 1, 3, 1, 1, 3, 1, 3, 1, 3, 6, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
